play_arbiter: RTL and testbench

Arbitrates the shared sound/LED/segment output path between the three play-mode engines: free, auto and learn. It tracks the one-hot mode switches and grants the output path to exactly one engine. On every grant change it inserts a silent gap and pulses a restart into the newly selected engine, so notes never glitch or carry over between modes. It sits between the mode engines and the buzzer, LED and seven-segment drivers.

---
 rtl/play_arbiter.sv | 132 +++++++++++++
 tb/tb_play_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/play_arbiter.sv
// Output-path arbiter for the free/auto/learn play engines.
// Every grant change inserts a silent gap and a one-cycle restart pulse to the new engine.
module play_arbiter #(
   parameter int MUTE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] mode,
   input  logic [3:0] free_note,
   input  logic [3:0] auto_note,
   input  logic [3:0] learn_note,
   input  logic [6:0] free_led,
   input  logic [6:0] auto_led,
   input  logic [6:0] learn_led,
   input  logic [1:0] free_octave,
   input  logic [1:0] auto_octave,
   input  logic [1:0] learn_octave,
   input  logic [3:0] free_num,
   input  logic [3:0] auto_num,
   input  logic [3:0] learn_num,
   output logic [3:0] note_out,
   output logic [6:0] led_out,
   output logic [1:0] octave_out,
   output logic [3:0] num,
   output logic [2:0] src_rst,
   output logic [2:0] active,
   output logic       busy
);

   localparam int CW = $clog2(MUTE_CYCLES) + 1;
   localparam logic [CW-1:0] LAST = CW'(MUTE_CYCLES - 1);
   localparam int DW = 17;

   typedef enum logic [1:0] {IDLE, MUTE, START, RUN} state_t;

   state_t          state_reg, state_next;
   logic [2:0]      target_reg, target_next;
   logic [CW-1:0]   count_reg, count_next;
   logic [DW-1:0]   data_reg, data_next;

   logic            mode_valid;
   logic [DW-1:0]   src_bus [3];
   logic [DW-1:0]   masked  [3];
   logic [DW-1:0]   granted;

   assign mode_valid = (mode == 3'b100) || (mode == 3'b010) || (mode == 3'b001);

   // Engine fields packed as {note, led, octave, num}, indexed like the mode bits.
   assign src_bus[2] = {free_note,  free_led,  free_octave,  free_num};
   assign src_bus[1] = {auto_note,  auto_led,  auto_octave,  auto_num};
   assign src_bus[0] = {learn_note, learn_led, learn_octave, learn_num};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_mask
         assign masked[gi] = target_reg[gi] ? src_bus[gi] : '0;
      end
   endgenerate

   assign granted = masked[0] | masked[1] | masked[2];

   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      count_next  = count_reg;
      data_next   = '0;
      case (state_reg)
         IDLE: begin
            if (mode_valid) begin
               state_next  = MUTE;
               target_next = mode;
               count_next  = '0;
            end
         end
         MUTE, START: begin
            if (!mode_valid) begin
               state_next  = IDLE;
               target_next = '0;
            end else if (mode != target_reg) begin
               state_next  = MUTE;
               target_next = mode;
               count_next  = '0;
            end else if (state_reg == START) begin
               state_next = RUN;
            end else if (count_reg == LAST) begin
               state_next = START;
            end else begin
               count_next = count_reg + CW'(1);
            end
         end
         RUN: begin
            if (!mode_valid) begin
               state_next  = IDLE;
               target_next = '0;
            end else if (mode != target_reg) begin
               state_next  = MUTE;
               target_next = mode;
               count_next  = '0;
            end else begin
               data_next = granted;
            end
         end
         default: begin
            state_next  = IDLE;
            target_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         target_reg <= '0;
         count_reg  <= '0;
         data_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         target_reg <= target_next;
         count_reg  <= count_next;
         data_reg   <= data_next;
      end
   end

   assign note_out   = data_reg[16:13];
   assign led_out    = data_reg[12:6];
   assign octave_out = data_reg[5:4];
   assign num        = data_reg[3:0];
   assign src_rst    = (state_reg == START) ? target_reg : 3'b000;
   assign active     = (state_reg == RUN) ? target_reg : 3'b000;
   assign busy       = (state_reg == MUTE) || (state_reg == START);

endmodule

// File: tb/tb_play_arbiter.sv
// Randomized bench for play_arbiter against a timestamp-based model of the grant rules.
// The model tracks only the current grant and how many edges ago it was chosen.
module tb_play_arbiter;

   localparam int M = 4;

   logic       clk;
   logic       reset;
   logic [2:0] mode;
   logic [3:0] free_note, auto_note, learn_note;
   logic [6:0] free_led, auto_led, learn_led;
   logic [1:0] free_octave, auto_octave, learn_octave;
   logic [3:0] free_num, auto_num, learn_num;
   logic [3:0] note_out;
   logic [6:0] led_out;
   logic [1:0] octave_out;
   logic [3:0] num;
   logic [2:0] src_rst;
   logic [2:0] active;
   logic       busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model: granted engine, edges since it was chosen, expected data.
   logic [2:0]  m_tgt;
   int          m_age;
   logic [16:0] m_data;

   play_arbiter #(.MUTE_CYCLES(M)) dut (
      .clk(clk), .reset(reset), .mode(mode),
      .free_note(free_note), .auto_note(auto_note), .learn_note(learn_note),
      .free_led(free_led), .auto_led(auto_led), .learn_led(learn_led),
      .free_octave(free_octave), .auto_octave(auto_octave), .learn_octave(learn_octave),
      .free_num(free_num), .auto_num(auto_num), .learn_num(learn_num),
      .note_out(note_out), .led_out(led_out), .octave_out(octave_out), .num(num),
      .src_rst(src_rst), .active(active), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [16:0] eng_data(input logic [2:0] sel);
      case (sel)
         3'b100:  return {free_note,  free_led,  free_octave,  free_num};
         3'b010:  return {auto_note,  auto_led,  auto_octave,  auto_num};
         3'b001:  return {learn_note, learn_led, learn_octave, learn_num};
         default: return '0;
      endcase
   endfunction

   task automatic model_reset();
      m_tgt  = 3'b000;
      m_age  = 0;
      m_data = '0;
   endtask

   // Applies the rules for one rising edge using the inputs present at that edge.
   task automatic model_edge();
      logic valid;
      if (reset) begin
         model_reset();
         return;
      end
      valid = (mode == 3'b100) || (mode == 3'b010) || (mode == 3'b001);
      if (m_tgt != 3'b000 && m_age >= M + 1 && mode == m_tgt)
         m_data = eng_data(m_tgt);
      else
         m_data = '0;
      if (!valid) begin
         m_tgt = 3'b000;
         m_age = 0;
      end else if (m_tgt == 3'b000 || mode != m_tgt) begin
         m_tgt = mode;
         m_age = 0;
      end else if (m_age < 1000) begin
         m_age++;
      end
   endtask

   task automatic check_all();
      logic [2:0] e_rst, e_act;
      logic       e_busy;
      e_rst  = (m_tgt != 3'b000 && m_age == M) ? m_tgt : 3'b000;
      e_act  = (m_tgt != 3'b000 && m_age >= M + 1) ? m_tgt : 3'b000;
      e_busy = (m_tgt != 3'b000 && m_age <= M);
      check("note",    32'(note_out),   32'(m_data[16:13]));
      check("led",     32'(led_out),    32'(m_data[12:6]));
      check("octave",  32'(octave_out), 32'(m_data[5:4]));
      check("num",     32'(num),        32'(m_data[3:0]));
      check("src_rst", 32'(src_rst),    32'(e_rst));
      check("active",  32'(active),     32'(e_act));
      check("busy",    32'(busy),       32'(e_busy));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      cyc++;
      $display("cyc=%0d rst=%b mode=%b note=%h active=%b src_rst=%b busy=%b",
               cyc, reset, mode, note_out, active, src_rst, busy);
   endtask

   task automatic rand_data();
      free_note  = 4'($urandom); auto_note  = 4'($urandom); learn_note  = 4'($urandom);
      free_led   = 7'($urandom); auto_led   = 7'($urandom); learn_led   = 7'($urandom);
      free_octave = 2'($urandom); auto_octave = 2'($urandom); learn_octave = 2'($urandom);
      free_num   = 4'($urandom); auto_num   = 4'($urandom); learn_num   = 4'($urandom);
   endtask

   task automatic check_zero_now(input string tag);
      check({tag, "_note"},  32'(note_out), 32'd0);
      check({tag, "_active"}, 32'(active),  32'd0);
      check({tag, "_busy"},  32'(busy),     32'd0);
      check({tag, "_rst"},   32'(src_rst),  32'd0);
   endtask

   initial begin
      model_reset();
      rand_data();
      reset = 1'b1;
      mode = 3'b010;
      auto_note = 4'd5;
      #1;
      check_zero_now("reset");
      step();
      step();
      @(negedge clk);
      reset = 1'b0;

      // Reset then auto: gap, pulse, then the engine's note.
      step();
      check("auto_busy1", 32'(busy), 32'd1);
      for (int i = 0; i < M; i++) step();
      check("auto_pulse", 32'(src_rst), 32'(3'b010));
      step();
      check("auto_nopulse", 32'(src_rst), 32'd0);
      step();
      check("auto_note", 32'(note_out), 32'd5);
      check("auto_active", 32'(active), 32'(3'b010));

      // Learn engine with stepping notes through the pass-through path.
      @(negedge clk);
      mode = 3'b001;
      for (int i = 0; i < M + 2; i++) step();
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         rand_data();
         learn_note = 4'(i);
         step();
         check("learn_follow", 32'(note_out), 32'(i));
      end

      // Async reset in the middle of a gap, then the gap starts over.
      @(negedge clk);
      mode = 3'b100;
      step();
      step();
      @(negedge clk);
      check("mute_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check_zero_now("async");
      model_reset();
      step();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < M + 3; i++) step();

      // Randomized mode changes, invalid modes, bounces and occasional resets.
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         reset = 1'b0;
         rand_data();
         if ($urandom_range(99) < 12) begin
            case ($urandom_range(9))
               0, 3:    mode = 3'b100;
               1, 4:    mode = 3'b010;
               2, 5:    mode = 3'b001;
               6:       mode = 3'b000;
               7:       mode = 3'b110;
               default: mode = 3'($urandom);
            endcase
         end
         if ($urandom_range(99) < 2) begin
            reset = 1'b1;
            #1;
            check_zero_now("rand_async");
            model_reset();
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
